// File: rtl/hex_page_display_pkg.sv
// Shared types and the 7-segment font for the paged hex viewer.
// Font values are abcdefg with a segment lit when its bit is 0.
package hex_disp_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_OFF = 7'b1111111;

  function automatic seg7_t hex_to_seg7(input logic [3:0] nib);
    seg7_t seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      4'hF:    seg = 7'b0111000;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_page_display_if.sv
// Bundle between the data source / board pins and the paged hex viewer.
// master drives the value, strobe, button and blank; slave drives the display.
interface hex_page_display_if #(
  parameter int DATA_W     = 64,
  parameter int NUM_DIGITS = 4,
  parameter int PAGE_W     = 2
);
  logic [DATA_W-1:0]     data_in;
  logic                  data_valid;
  logic                  psh;
  logic                  blank;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;
  logic [PAGE_W-1:0]     page;

  modport master (
    output data_in, data_valid, psh, blank,
    input  seg, an, page
  );

  modport slave (
    input  data_in, data_valid, psh, blank,
    output seg, an, page
  );
endinterface

// File: rtl/hex_page_display_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             rise_r;
  logic [CNT_W-1:0] cnt_r;

  // The count runs only while the synchronised input differs from the accepted
  // level, so a bounce back to the old level restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      rise_r  <= 1'b0;
      if (sync2_r != level_r) begin
        if (cnt_r == CNT_MAX) begin
          level_r <= sync2_r;
          rise_r  <= sync2_r;
          cnt_r   <= '0;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/hex_page_display.sv
// Paged, time-multiplexed hex viewer: holds a snapshot of a wide word and
// scans one page of NUM_DIGITS nibbles at a time onto a 7-segment display.
module hex_page_display
  import hex_disp_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_CYC   = 500000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input logic               clk,
  input logic               rst,
  hex_page_display_if.slave bus
);

  localparam int NUM_PAGES = DATA_W / (4 * NUM_DIGITS);
  localparam int PAGE_W    = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TICK_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [NUM_DIGITS-1:0] AN_IDLE =
    (SEG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam seg7_t SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;

  logic [DATA_W-1:0]     snap_r;
  logic [PAGE_W-1:0]     page_r;
  logic [IDX_W-1:0]      idx_r;
  logic [TICK_W-1:0]     tick_r;
  logic [NUM_DIGITS-1:0] an_r;
  seg7_t                 seg_r;

  logic                  rise_s;
  logic [31:0]           pos_s;
  logic [31:0]           sh_s;
  logic [3:0]            nib_s;
  seg7_t                 font_s;
  logic [NUM_DIGITS-1:0] an_on_s;
  logic [NUM_DIGITS-1:0] an_nx_s;
  seg7_t                 seg_nx_s;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_btn (
    .clk  (clk),
    .rst  (rst),
    .btn  (bus.psh),
    .rise (rise_s)
  );

  // Snapshot and page: a capture always wins over a page step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_r <= '0;
      page_r <= '0;
    end else if (bus.data_valid) begin
      snap_r <= bus.data_in;
      page_r <= '0;
    end else if (rise_s && (NUM_PAGES > 1)) begin
      if (page_r == PAGE_W'(NUM_PAGES - 1)) begin
        page_r <= '0;
      end else begin
        page_r <= page_r + PAGE_W'(1);
      end
    end else begin
      page_r <= page_r;
    end
  end

  // Scan divider and digit index; keeps running while blanked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_r <= '0;
      idx_r  <= '0;
    end else if (tick_r == TICK_W'(SCAN_DIV - 1)) begin
      tick_r <= '0;
      if (idx_r == IDX_W'(NUM_DIGITS - 1)) begin
        idx_r <= '0;
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end else begin
      tick_r <= tick_r + TICK_W'(1);
    end
  end

  // Page 0 digit 0 is the most significant nibble of the snapshot.
  always_comb begin
    pos_s   = 32'(page_r) * 32'(NUM_DIGITS) + 32'(idx_r);
    sh_s    = 32'(DATA_W - 4) - (32'd4 * pos_s);
    nib_s   = 4'(snap_r >> sh_s);
    font_s  = hex_to_seg7(nib_s);
    an_on_s = {NUM_DIGITS{1'b0}};
    if (!bus.blank) begin
      an_on_s[idx_r] = 1'b1;
    end else begin
      an_on_s = {NUM_DIGITS{1'b0}};
    end
    if (SEG_ACTIVE_LOW != 0) begin
      an_nx_s  = ~an_on_s;
      seg_nx_s = font_s;
    end else begin
      an_nx_s  = an_on_s;
      seg_nx_s = ~font_s;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_r  <= AN_IDLE;
      seg_r <= SEG_IDLE;
    end else begin
      an_r  <= an_nx_s;
      seg_r <= seg_nx_s;
    end
  end

  assign bus.an   = an_r;
  assign bus.seg  = seg_r;
  assign bus.page = page_r;

endmodule

// File: tb/tb_hex_page_display.sv
// Directed bench for hex_page_display with short scan/debounce periods and
// a second, active-high build driven by the same stimulus.
module tb_hex_page_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hex_page_display_if #(.DATA_W(64), .NUM_DIGITS(4), .PAGE_W(2)) ifc ();
  hex_page_display_if #(.DATA_W(64), .NUM_DIGITS(4), .PAGE_W(2)) ifc2 ();

  assign ifc2.data_in    = ifc.data_in;
  assign ifc2.data_valid = ifc.data_valid;
  assign ifc2.psh        = ifc.psh;
  assign ifc2.blank      = ifc.blank;

  hex_page_display #(
    .DATA_W(64), .NUM_DIGITS(4), .SCAN_DIV(4), .DEBOUNCE_CYC(8), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  hex_page_display #(
    .DATA_W(64), .NUM_DIGITS(4), .SCAN_DIV(4), .DEBOUNCE_CYC(8), .SEG_ACTIVE_LOW(0)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (ifc2.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // strict: the digit must already be showing and must last exactly 4 cycles.
  task automatic show_digit(input string tag, input logic [3:0] exp_an,
                            input logic [6:0] exp_seg, input bit strict);
    int n;
    n = 0;
    if (!strict) begin
      while (ifc.an !== exp_an && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    chk({tag, "_an"}, 64'(ifc.an), 64'(exp_an));
    chk({tag, "_seg"}, 64'(ifc.seg), 64'(exp_seg));
    n = 0;
    while (ifc.an === exp_an && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (strict) chk({tag, "_hold"}, 64'(n), 64'd4);
  endtask

  task automatic press(input int hi);
    ifc.psh = 1'b1;
    repeat (hi) @(negedge clk);
    ifc.psh = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic capture(input logic [63:0] d);
    ifc.data_in    = d;
    ifc.data_valid = 1'b1;
    @(negedge clk);
    ifc.data_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    ifc.data_in    = 64'd0;
    ifc.data_valid = 1'b0;
    ifc.psh        = 1'b0;
    ifc.blank      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an2", 64'(ifc2.an), 64'h0);
    chk("rst_seg2", 64'(ifc2.seg), 64'h0);
    rst = 1'b0;
    chk("rel_an", 64'(ifc.an), 64'hF);
    chk("rel_seg", 64'(ifc.seg), 64'h7F);
    chk("rel_page", 64'(ifc.page), 64'd0);

    capture(64'h0123456789ABCDEF);
    show_digit("p0d0", 4'b1110, 7'b0000001, 1'b0);
    show_digit("p0d1", 4'b1101, 7'b1001111, 1'b1);
    show_digit("p0d2", 4'b1011, 7'b0010010, 1'b1);
    show_digit("p0d3", 4'b0111, 7'b0000110, 1'b1);
    chk("hi_an", 64'(ifc2.an), 64'b0001);
    chk("hi_seg", 64'(ifc2.seg), 64'b1111110);

    press(12);
    chk("page1", 64'(ifc.page), 64'd1);
    show_digit("p1d0", 4'b1110, 7'b1001100, 1'b0);
    show_digit("p1d1", 4'b1101, 7'b0100100, 1'b1);
    show_digit("p1d2", 4'b1011, 7'b0100000, 1'b1);
    show_digit("p1d3", 4'b0111, 7'b0001111, 1'b1);
    press(12);
    chk("page2", 64'(ifc.page), 64'd2);
    press(12);
    chk("page3", 64'(ifc.page), 64'd3);
    press(12);
    chk("wrap", 64'(ifc.page), 64'd0);
    show_digit("wrap_d0", 4'b1110, 7'b0000001, 1'b0);

    press(12);
    chk("page1b", 64'(ifc.page), 64'd1);
    press(3);
    chk("glitch", 64'(ifc.page), 64'd1);

    // Strobe straddles the edge on which the accepted press would step the page.
    ifc.psh = 1'b1;
    repeat (9) @(negedge clk);
    ifc.data_in    = 64'hFEDCBA9876543210;
    ifc.data_valid = 1'b1;
    repeat (3) @(negedge clk);
    ifc.data_valid = 1'b0;
    ifc.psh        = 1'b0;
    repeat (14) @(negedge clk);
    chk("coinc_page", 64'(ifc.page), 64'd0);
    show_digit("coinc_d0", 4'b1110, 7'b0111000, 1'b0);

    capture(64'h0123456789ABCDEF);
    press(12);
    press(12);
    chk("page2b", 64'(ifc.page), 64'd2);
    show_digit("p2d0", 4'b1110, 7'b0000000, 1'b0);
    show_digit("p2d1", 4'b1101, 7'b0000100, 1'b1);
    show_digit("p2d2", 4'b1011, 7'b0001000, 1'b1);
    chk("p2d3_an", 64'(ifc.an), 64'b0111);
    chk("p2d3_seg", 64'(ifc.seg), 64'b1100000);
    ifc.blank = 1'b1;
    @(negedge clk);
    chk("blank_an", 64'(ifc.an), 64'hF);
    ifc.blank = 1'b0;
    @(negedge clk);
    chk("unblank_an", 64'(ifc.an), 64'b0111);
    chk("unblank_seg", 64'(ifc.seg), 64'b1100000);

    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_an", 64'(ifc.an), 64'hF);
    chk("arst_seg", 64'(ifc.seg), 64'h7F);
    chk("arst_page", 64'(ifc.page), 64'd0);
    chk("arst_an2", 64'(ifc2.an), 64'h0);
    chk("arst_seg2", 64'(ifc2.seg), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
